// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if
//   Receive-side handshake bundle between the UART framer and its consumer.
//   rx_data     : received word, stable while rx_valid is high
//   rx_valid    : word available, held until accepted
//   rx_ready    : consumer accepts when rx_valid & rx_ready at a clk edge
//   frame_err   : 1-cycle pulse, stop bit sampled low
//   parity_err  : 1-cycle pulse, parity mismatch
//   overrun_err : 1-cycle pulse, frame completed while a word was still pending
//   master = framer side, slave = consumer side.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   UART receive framer. Synchronizes rx, qualifies the start bit at mid-bit,
//   then aligns the downstream baud generator so every baud_tick lands mid-bit.
//   Samples data LSB first, optional parity and the stop bit, and hands the
//   word out over a valid/ready handshake with framing/parity/overrun flags.
// Ports
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : asynchronous serial line, idle high
//   baud_tick   : 1-cycle mid-bit strobe from baud_gen
//   baud_en     : enable to baud_gen (align cycle and DATA/PARITY/STOP)
//   baud_align  : 1-cycle align pulse to baud_gen
//   busy        : high whenever the FSM is not IDLE
//   rx_if       : handshake and error flags (master side)
module uart_rx_frame #(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic                   baud_tick,
    output logic                   baud_en,
    output logic                   baud_align,
    output logic                   busy,
    uart_rx_frame_if.master        rx_if
);

    localparam int DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF    = DIVISOR / 2;
    localparam int HCW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BCW     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    // Even-parity reduction of a data word.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction

    logic                 rx_meta_q, rx_sync_q, rx_s;
    state_e               state_q, state_d;
    logic [HCW-1:0]       half_q, half_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_mis_q, par_mis_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d, pe_q, pe_d, oe_q, oe_d;
    logic                 align_q, align_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;

    assign rx_s = rx_sync_q;

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state and next-output computation for the framer.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_mis_d = par_mis_q;
        data_d    = data_q;
        // An accept this edge retires the pending word before any new word lands.
        valid_d   = valid_q & ~rx_if.rx_ready;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
        oe_d      = 1'b0;
        align_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    half_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (half_q == HCW'(HALF - 1)) begin
                    if (!rx_s) begin
                        align_d   = 1'b1;
                        bit_d     = '0;
                        par_mis_d = 1'b0;
                        state_d   = DATA;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    half_d = half_q + HCW'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BCW'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    par_mis_d = rx_s ^ parity_of(shift_q) ^ 1'(PARITY_ODD);
                    state_d   = STOP;
                end else begin
                    state_d   = PARITY;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (!rx_s) begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end else if (par_mis_q) begin
                        pe_d    = 1'b1;
                        state_d = IDLE;
                    end else if (valid_q && !rx_if.rx_ready) begin
                        oe_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                // Hold here until the line returns high so a stuck-low line cannot restart a frame.
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        en_d   = (state_d == DATA) || (state_d == PARITY) || (state_d == STOP);
        busy_d = (state_d != IDLE);
    end

    // Framer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            half_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_mis_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            oe_q      <= 1'b0;
            align_q   <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_mis_q <= par_mis_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            oe_q      <= oe_d;
            align_q   <= align_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_if.rx_data     = data_q;
    assign rx_if.rx_valid    = valid_q;
    assign rx_if.frame_err   = fe_q;
    assign rx_if.parity_err  = pe_q;
    assign rx_if.overrun_err = oe_q;
    assign baud_align        = align_q;
    assign baud_en           = en_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
//   Directed bench for uart_rx_frame: an 8N1 instance (dut0) and an 8E1
//   instance (dut1), each paired with a small baud generator model
//   (1 bit = 16 clk, align restarts the count, tick at count 15).
module tb_uart_rx_frame;

    logic clk = 1'b0;
    logic rst_n;
    logic rx0, rx1;
    logic tick0, tick1, en0, en1, align0, align1, busy0, busy1;
    logic [3:0] bcnt0, bcnt1;

    int n_vec = 0;
    int n_err = 0;
    int n_acc0 = 0, n_fe0 = 0, n_pe0 = 0, n_oe0 = 0, n_align0 = 0, n_en0 = 0;
    int n_acc1 = 0, n_fe1 = 0, n_pe1 = 0, n_oe1 = 0;
    int a_snap, e_snap;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    uart_rx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_rx_frame_if #(.DATA_BITS(8)) if1 ();

    uart_rx_frame #(.CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                    .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .baud_tick(tick0),
        .baud_en(en0), .baud_align(align0), .busy(busy0), .rx_if(if0));

    uart_rx_frame #(.CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                    .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .baud_tick(tick1),
        .baud_en(en1), .baud_align(align1), .busy(busy1), .rx_if(if1));

    // Baud generator models.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               bcnt0 <= 4'd0;
        else if (!en0 || align0)  bcnt0 <= 4'd0;
        else                      bcnt0 <= bcnt0 + 4'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               bcnt1 <= 4'd0;
        else if (!en1 || align1)  bcnt1 <= 4'd0;
        else                      bcnt1 <= bcnt1 + 4'd1;
    end
    assign tick0 = en0 && !align0 && (bcnt0 == 4'd15);
    assign tick1 = en1 && !align1 && (bcnt1 == 4'd15);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else          rx1 = b;
        wait_clk(16);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic par_present,
                        input logic par_bit, input logic stop_bit, input int idle_bits);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_present) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
        for (int i = 0; i < idle_bits; i++) drive_bit(sel, 1'b1);
    endtask

    // Output monitor: counts pulses and scores accepted words against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.frame_err)   n_fe0++;
            if (if0.parity_err)  n_pe0++;
            if (if0.overrun_err) n_oe0++;
            if (align0)          n_align0++;
            if (en0)             n_en0++;
            if (if1.frame_err)   n_fe1++;
            if (if1.parity_err)  n_pe1++;
            if (if1.overrun_err) n_oe1++;
            if (if0.rx_valid && if0.rx_ready) begin
                n_acc0++;
                check("acc0_expected", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) check("acc0_data", 32'(if0.rx_data), 32'(q0.pop_front()));
            end
            if (if1.rx_valid && if1.rx_ready) begin
                n_acc1++;
                check("acc1_expected", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) check("acc1_data", 32'(if1.rx_data), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        wait_clk(3);
        check("rst_valid", 32'(if0.rx_valid), 32'd0);
        check("rst_data",  32'(if0.rx_data),  32'd0);
        check("rst_busy",  32'(busy0),        32'd0);
        check("rst_en",    32'(en0),          32'd0);
        check("rst_align", 32'(align0),       32'd0);
        check("rst_flags", 32'({if0.frame_err, if0.parity_err, if0.overrun_err}), 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // 1: plain 8N1 byte
        q0.push_back(8'hA5);
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 2);
        check("t1_acc",   32'(n_acc0), 32'd1);
        check("t1_busy",  32'(busy0),  32'd0);
        check("t1_flags", 32'(n_fe0 + n_pe0 + n_oe0), 32'd0);
        check("t1_align", 32'(n_align0), 32'd1);

        // 2: start-bit glitch
        a_snap = n_align0;
        e_snap = n_en0;
        rx0 = 1'b0;
        wait_clk(4);
        rx0 = 1'b1;
        wait_clk(30);
        check("t2_align", 32'(n_align0 - a_snap), 32'd0);
        check("t2_en",    32'(n_en0 - e_snap),    32'd0);
        check("t2_busy",  32'(busy0),             32'd0);
        check("t2_flags", 32'(n_fe0 + n_pe0 + n_oe0), 32'd0);

        // 3: framing error, held-low line, then a good byte
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
        wait_clk(40);
        check("t3_break_busy", 32'(busy0), 32'd1);
        check("t3_fe",         32'(n_fe0), 32'd1);
        rx0 = 1'b1;
        wait_clk(32);
        check("t3_idle_busy", 32'(busy0), 32'd0);
        q0.push_back(8'h5A);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 2);
        check("t3_acc", 32'(n_acc0), 32'd2);
        check("t3_fe_once", 32'(n_fe0), 32'd1);

        // 4: overrun with consumer stalled
        if0.rx_ready = 1'b0;
        q0.push_back(8'h11);
        send(0, 8'h11, 1'b0, 1'b0, 1'b1, 2);
        check("t4_valid1", 32'(if0.rx_valid), 32'd1);
        check("t4_data1",  32'(if0.rx_data),  32'h11);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, 2);
        check("t4_oe",     32'(n_oe0),        32'd1);
        check("t4_data2",  32'(if0.rx_data),  32'h11);
        check("t4_valid2", 32'(if0.rx_valid), 32'd1);
        if0.rx_ready = 1'b1;
        wait_clk(2);
        check("t4_cleared", 32'(if0.rx_valid), 32'd0);
        check("t4_acc",     32'(n_acc0),       32'd3);

        // 5: even parity on dut1 (0x07 needs parity bit 1)
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, 2);
        check("t5_pe",      32'(n_pe1),  32'd1);
        check("t5_novalid", 32'(n_acc1), 32'd0);
        q1.push_back(8'h07);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 2);
        check("t5_acc",     32'(n_acc1), 32'd1);
        check("t5_pe_once", 32'(n_pe1 + n_fe1 + n_oe1), 32'd1);

        // 6: reset during data bit 4 of 0xFF
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        wait_clk(8);
        rst_n = 1'b0;
        wait_clk(2);
        check("t6_valid", 32'(if0.rx_valid), 32'd0);
        check("t6_data",  32'(if0.rx_data),  32'd0);
        check("t6_busy",  32'(busy0),        32'd0);
        check("t6_en",    32'(en0),          32'd0);
        check("t6_data1", 32'(if1.rx_data),  32'd0);
        wait_clk(16);
        rst_n = 1'b1;
        wait_clk(32);
        check("t6_flags", 32'({8'(n_fe0), 8'(n_pe0), 8'(n_oe0)}), 32'h010001);
        q0.push_back(8'h81);
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, 2);
        check("t6_acc", 32'(n_acc0), 32'd4);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
